// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers and FSM state encoding
package aes_pkg;

    // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x (0x02) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // 0x09 = x^3 + 1
    function automatic logic [7:0] gmul9(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    // 0x0b = x^3 + x + 1
    function automatic logic [7:0] gmul11(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    // 0x0d = x^3 + x^2 + 1
    function automatic logic [7:0] gmul13(input logic [7:0] x);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    // 0x0e = x^3 + x^2 + x
    function automatic logic [7:0] gmul14(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mixcolumn_iter_if.sv
// rtl/inv_mixcolumn_iter_if.sv - input/output handshake bundle for inv_mixcolumn_iter
interface inv_mixcolumn_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    // Upstream/downstream side driving the block
    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The transform block itself
    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/inv_mixcolumn_iter_col32.sv
// rtl/inv_mixcolumn_iter_col32.sv - combinational InvMixColumns of one 32-bit column
module inv_mixcolumn32
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;

    // Row 0 is the most significant byte of the column
    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Circulant matrix [0e 0b 0d 09], each row rotated right by one
    assign col_out[31:24] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign col_out[23:16] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign col_out[15:8]  = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign col_out[7:0]   = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);

endmodule

// File: rtl/inv_mixcolumn_iter.sv
// rtl/inv_mixcolumn_iter.sv - iterative AES InvMixColumns stage with valid/ready handshake
module inv_mixcolumn_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    inv_mixcolumn_iter_if.slave bus
);

    localparam int         NCOL     = COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] GRP_STEP = 2'(COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("inv_mixcolumn_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t              state;
    logic [1:0]          col_cnt;
    logic [127:0]        data_q;
    logic [127:0]        busy_data;
    logic [32*NCOL-1:0]  grp_out;
    logic                in_ready_w;
    logic                accept;

    // A finished state can be handed off in the same cycle the next one arrives
    assign in_ready_w = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign accept     = bus.in_valid & in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = data_q;

    // One column engine per lane; lane j works on column col_cnt + j
    for (genvar j = 0; j < NCOL; j++) begin : g_col
        logic [1:0]  idx;
        logic [31:0] cin;
        logic [31:0] cout;

        assign idx = col_cnt + 2'(j);

        // Select the column this lane transforms in the current group
        always_comb begin
            case (idx)
                2'd0:    cin = data_q[127:96];
                2'd1:    cin = data_q[95:64];
                2'd2:    cin = data_q[63:32];
                default: cin = data_q[31:0];
            endcase
        end

        inv_mixcolumn32 u_col (
            .col_in  (cin),
            .col_out (cout)
        );

        assign grp_out[32*j +: 32] = cout;
    end

    // Write the transformed group back over its own columns, leave the rest alone
    always_comb begin
        busy_data = data_q;
        for (int j = 0; j < NCOL; j++) begin
            case (col_cnt + 2'(j))
                2'd0:    busy_data[127:96] = grp_out[32*j +: 32];
                2'd1:    busy_data[95:64]  = grp_out[32*j +: 32];
                2'd2:    busy_data[63:32]  = grp_out[32*j +: 32];
                default: busy_data[31:0]   = grp_out[32*j +: 32];
            endcase
        end
    end

    // Control FSM and in-place state register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            col_cnt <= 2'd0;
            data_q  <= 128'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        data_q  <= bus.in_data;
                        col_cnt <= 2'd0;
                        state   <= bus.in_bypass ? DONE : BUSY;
                    end else if (state == DONE && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    data_q <= busy_data;
                    if (col_cnt == LAST_GRP) begin
                        col_cnt <= 2'd0;
                        state   <= DONE;
                    end else begin
                        col_cnt <= col_cnt + GRP_STEP;
                    end
                end
                default: begin
                    state   <= IDLE;
                    col_cnt <= 2'd0;
                end
            endcase
        end
    end

    // A stalled result must not move until downstream takes it
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_data)));

    // The group counter only ever lands on group boundaries
    a_grp_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(col_cnt) % NCOL) == 0);

endmodule

// File: tb/tb_inv_mixcolumn_iter.sv
// tb/tb_inv_mixcolumn_iter.sv - scoreboard bench for inv_mixcolumn_iter at CPC 1, 2 and 4
module tb_inv_mixcolumn_iter;

    typedef struct packed {
        logic [127:0] d;
        int           lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_fail = 0;

    logic [2:0]        in_valid;
    logic [2:0]        in_bypass;
    logic [2:0]        out_ready;
    logic [2:0][127:0] in_data;
    logic [2:0]        in_ready;
    logic [2:0]        out_valid;
    logic [2:0][127:0] out_data;

    exp_t exp_q [3][$];
    int   acc_q [3][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward (encrypt) MixColumns, used to build round-trip stimulus
    function automatic logic [127:0] mix_state(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int CPC = (k == 0) ? 1 : ((k == 1) ? 2 : 4);

        inv_mixcolumn_iter_if bus ();

        assign bus.in_valid  = in_valid[k];
        assign bus.in_data   = in_data[k];
        assign bus.in_bypass = in_bypass[k];
        assign bus.out_ready = out_ready[k];
        assign in_ready[k]   = bus.in_ready;
        assign out_valid[k]  = bus.out_valid;
        assign out_data[k]   = bus.out_data;

        inv_mixcolumn_iter #(.COLS_PER_CYCLE(CPC)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        bit   seen = 1'b0;
        int   a;
        exp_t e;

        // Monitor: records accepts, checks latency on first sight and data on retirement
        always @(negedge clk) begin
            if (!rst_n) begin
                seen = 1'b0;
            end else begin
                if (in_valid[k] && in_ready[k]) acc_q[k].push_back(cyc);
                if (out_valid[k] && !seen) begin
                    seen = 1'b1;
                    if (acc_q[k].size() == 0 || exp_q[k].size() == 0) begin
                        chk($sformatf("orphan_output_cpc%0d", CPC), 128'(out_valid[k]), 128'd0);
                    end else begin
                        a = acc_q[k].pop_front();
                        if (exp_q[k][0].lat != 0)
                            chk($sformatf("latency_cpc%0d", CPC), 128'(cyc - a), 128'(exp_q[k][0].lat));
                    end
                end
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("unexpected_output_cpc%0d", CPC), out_data[k], 128'hx);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("data_cpc%0d", CPC), out_data[k], e.d);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    // Present one state; returns one posedge + 1 after the accept edge
    task automatic send(input int k, input logic [127:0] d, input logic byp,
                        input logic [127:0] e, input int lat, output int waited);
        exp_t x;
        x.d   = e;
        x.lat = lat;
        exp_q[k].push_back(x);
        in_valid[k]  = 1'b1;
        in_data[k]   = d;
        in_bypass[k] = byp;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready[k] && waited < 500);
        if (!in_ready[k]) chk("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid[k]  = 1'b0;
        in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
        in_bypass[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q[k].size() != 0 && n < 2000);
        #1;
        if (exp_q[k].size() != 0) chk("drain_timeout", 128'(exp_q[k].size()), 128'd0);
    endtask

    localparam logic [127:0] FULL_IN  = 128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc;
    localparam logic [127:0] FULL_OUT = 128'h2d26314c_d4d4d4d5_f20a225c_db135345;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic [31:0] col_in_v  [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    logic [31:0] col_out_v [4] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    int          lat_v     [3] = '{5, 3, 2};

    initial begin
        int w;
        int n;
        bit rt_done;
        logic [127:0] st;

        in_valid  = '0;
        in_bypass = '0;
        out_ready = '0;
        in_data   = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_out_valid", 128'(out_valid[k]), 128'd0);
            chk("reset_out_data", out_data[k], 128'd0);
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("reset_in_ready", 128'(in_ready[k]), 128'd1);
        out_ready = 3'b111;
        @(posedge clk);
        #1;

        // Single-column vectors in column 0
        for (int i = 0; i < 4; i++) send(0, {col_in_v[i], 96'd0}, 1'b0, {col_out_v[i], 96'd0}, 5, w);
        drain(0);

        // Full state on every column-parallelism
        for (int k = 0; k < 3; k++) begin
            send(k, FULL_IN, 1'b0, FULL_OUT, lat_v[k], w);
            send(k, FULL_IN, 1'b0, FULL_OUT, lat_v[k], w);
            drain(k);
        end

        // Bypass, including back-to-back
        send(0, BYP_IN, 1'b1, BYP_IN, 1, w);
        send(0, FULL_IN, 1'b1, FULL_IN, 1, w);
        drain(0);

        // Backpressure then same-cycle handoff
        out_ready[0] = 1'b0;
        send(0, FULL_IN, 1'b0, FULL_OUT, 5, w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[0] && n < 20);
        chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_data_stable", out_data[0], FULL_OUT);
            chk("bp_in_ready_low", 128'(in_ready[0]), 128'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, {col_in_v[1], 96'd0}, 1'b0, {col_out_v[1], 96'd0}, 5, w);
        chk("handoff_same_cycle", 128'(w), 128'd1);
        drain(0);

        // Round trip through forward MixColumns with random throttling
        rt_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    st = {$urandom, $urandom, $urandom, $urandom};
                    send(0, mix_state(st), 1'b0, st, 5, w);
                end
                drain(0);
                rt_done = 1'b1;
            end
            begin
                while (!rt_done) begin
                    @(posedge clk);
                    #1;
                    out_ready[0] = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset while BUSY at col_cnt = 2
        send(0, FULL_IN, 1'b0, FULL_OUT, 5, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q[0].delete();
        acc_q[0].delete();
        #1;
        chk("midreset_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midreset_out_data", out_data[0], 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midreset_in_ready", 128'(in_ready[0]), 128'd1);
        send(0, FULL_IN, 1'b0, FULL_OUT, 5, w);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
